// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LAT_W      = 3;

  // Producer latency classes; LAT_INF marks a variable-latency producer that
  // is retired only by a writeback handshake.
  typedef enum logic [LAT_W-1:0] {
    LAT_FWD  = 3'd0,
    LAT_LOAD = 3'd1,
    LAT_INF  = 3'd7
  } lat_class_e;

  // Pipeline stall/flush controls in one bundle.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_if;
    logic flush_id;
    logic flush_ex;
  } hazard_ctrl_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending bit, latency countdown and a sticky flag for
// writebacks that do not match a pending variable-latency producer.
module sb_entry #(
  parameter int LAT_W   = 3,
  parameter int LAT_INF = 2**LAT_W-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_hit,   // issuing instruction writes this register
  input  logic [LAT_W-1:0] set_lat,     // latency of that instruction
  input  logic             wb_hit,      // writeback addresses this register
  output logic             pending,
  output logic [LAT_W-1:0] cnt,
  output logic             err
);

  localparam logic [LAT_W-1:0] CNT_INF = LAT_W'(LAT_INF);

  logic             pending_d, pending_q;
  logic [LAT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;
  logic             inf_pending;

  assign inf_pending = pending_q && (cnt_q == CNT_INF);

  // Next-state: issue reloads, else writeback retires, else countdown.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    pending_d = pending_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (wb_hit && !inf_pending) begin
      err_d = 1'b1;
    end

    if (issue_hit) begin
      if (set_lat != '0) begin
        pending_d = 1'b1;
        cnt_d     = set_lat;
      end else begin
        // Forwardable result supersedes any older entry.
        pending_d = 1'b0;
        cnt_d     = '0;
      end
    end else if (wb_hit && inf_pending) begin
      pending_d = 1'b0;
      cnt_d     = '0;
    end else if (pending_q && (cnt_q != CNT_INF)) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == LAT_W'(1)) begin
        pending_d = 1'b0;
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop here is control state, so all are reset; non-blocking assignments keep edge semantics.
    if (!rst_n) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign cnt     = cnt_q;
  assign err     = err_q;

`ifndef SYNTHESIS
  a_no_zero_cnt_pending: assert property (@(posedge clk) disable iff (!rst_n)
    !(pending_q && (cnt_q == '0)));
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: tracks in-flight register writes, stalls ID on RAW
// and WAW-against-variable-latency, and lets EX redirects override stalls.
module hazard_scoreboard
  import hazard_pkg::hazard_ctrl_t;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LAT_W      = 3,
  parameter int LAT_INF    = 2**LAT_W-1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_reg_write,
  input  logic [LAT_W-1:0]              id_latency,
  input  logic                          ex_redirect,
  input  logic                          wb_valid,
  input  logic [REG_ADDR_W-1:0]         wb_rd_addr,
  output logic                          stall_if,
  output logic                          stall_id,
  output logic                          flush_if,
  output logic                          flush_id,
  output logic                          flush_ex,
  output logic [NUM_REGS-1:0]           pending_mask,
  output logic                          err_spurious_wb
);

  localparam logic [LAT_W-1:0] CNT_INF = LAT_W'(LAT_INF);

  logic [NUM_REGS-1:0] pend;
  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] err_vec;

  logic                  raw, waw, hazard, issue;
  logic [REG_ADDR_W-1:0] rs;
  hazard_ctrl_t          ctrl;

  // x0 is never tracked.
  assign pend[0]    = 1'b0;
  assign cnt[0]     = '0;
  assign err_vec[0] = 1'b0;

  // Hazard compare of ID operands against the pending entries.
  always_comb begin
    raw = 1'b0;
    rs  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (id_rs_used[i] && (rs != '0) && pend[rs]) begin
        raw = 1'b1;
      end
    end
    // A younger variable-latency write must wait, or the older writeback would clear it.
    waw    = id_reg_write && (id_rd_addr != '0) && pend[id_rd_addr] &&
             (cnt[id_rd_addr] == CNT_INF);
    hazard = id_valid && (raw || waw);
  end

  // Priority: redirect flushes and suppresses stalls; otherwise hazards stall.
  always_comb begin
    ctrl = '0;
    if (ex_redirect) begin
      ctrl.flush_if = 1'b1;
      ctrl.flush_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end else if (hazard) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end
  end

  assign issue = id_valid && !ctrl.stall_id && !ctrl.flush_id;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .LAT_W   (LAT_W),
      .LAT_INF (LAT_INF)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue_hit (issue && id_reg_write && (id_rd_addr == REG_ADDR_W'(r))),
      .set_lat   (id_latency),
      .wb_hit    (wb_valid && (wb_rd_addr == REG_ADDR_W'(r))),
      .pending   (pend[r]),
      .cnt       (cnt[r]),
      .err       (err_vec[r])
    );
  end

  // Combinational controls are held low while reset is asserted.
  assign stall_if        = ctrl.stall_if && rst_n;
  assign stall_id        = ctrl.stall_id && rst_n;
  assign flush_if        = ctrl.flush_if && rst_n;
  assign flush_id        = ctrl.flush_id && rst_n;
  assign flush_ex        = ctrl.flush_ex && rst_n;
  assign pending_mask    = pend;
  assign err_spurious_wb = |err_vec;

`ifndef SYNTHESIS
  a_no_stall_and_flush: assert property (@(posedge clk) disable iff (!rst_n)
    !(stall_if && flush_if) && !(stall_id && flush_id));
  a_x0_never_pending: assert property (@(posedge clk) pending_mask[0] == 1'b0);
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by a
// random phase, all checked against a remaining-cycles reference model.
module tb_hazard_scoreboard;

  localparam int NR   = 32;
  localparam int AW   = 5;
  localparam int NS   = 2;
  localparam int LW   = 3;
  localparam int LINF = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               id_valid;
  logic [NS*AW-1:0]   id_rs_addr;
  logic [NS-1:0]      id_rs_used;
  logic [AW-1:0]      id_rd_addr;
  logic               id_reg_write;
  logic [LW-1:0]      id_latency;
  logic               ex_redirect;
  logic               wb_valid;
  logic [AW-1:0]      wb_rd_addr;
  logic               stall_if, stall_id, flush_if, flush_id, flush_ex;
  logic [NR-1:0]      pending_mask;
  logic               err_spurious_wb;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles until each register's value is forwardable
  // (0 = free, -1 = waiting for writeback).
  int rem [NR];
  bit merr;

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW), .LAT_INF(LINF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_latency(id_latency), .ex_redirect(ex_redirect), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .stall_if(stall_if), .stall_id(stall_id),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .pending_mask(pending_mask), .err_spurious_wb(err_spurious_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (rem[r]) rem[r] = 0;
    merr = 1'b0;
  endtask

  task automatic drive_id(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                          input int rd, input bit rw, input int lat);
    id_valid     = v;
    id_rs_addr   = {AW'(rs1), AW'(rs0)};
    id_rs_used   = used;
    id_rd_addr   = AW'(rd);
    id_reg_write = rw;
    id_latency   = LW'(lat);
  endtask

  task automatic idle();
    drive_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 0);
  endtask

  function automatic bit m_hazard();
    bit hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int a = int'(id_rs_addr[i*AW +: AW]);
      if (id_rs_used[i] && a != 0 && rem[a] != 0) hz = 1'b1;
    end
    if (id_reg_write && id_rd_addr != 0 && rem[id_rd_addr] == -1) hz = 1'b1;
    return id_valid && hz;
  endfunction

  // Expected {stall_if, stall_id, flush_if, flush_id, flush_ex}.
  function automatic logic [4:0] m_ctrl();
    if (ex_redirect) return 5'b00111;
    if (m_hazard()) return 5'b11001;
    return 5'b00000;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < NR; r++) m[r] = (rem[r] != 0);
    return m;
  endfunction

  task automatic m_update(input bit issue);
    int nr [NR];
    for (int r = 0; r < NR; r++) nr[r] = (rem[r] > 0) ? rem[r] - 1 : rem[r];
    if (wb_valid && wb_rd_addr != 0) begin
      if (rem[wb_rd_addr] == -1) nr[wb_rd_addr] = 0;
      else merr = 1'b1;
    end
    if (issue && id_reg_write && id_rd_addr != 0)
      nr[id_rd_addr] = (int'(id_latency) == LINF) ? -1 : int'(id_latency);
    rem = nr;
  endtask

  // One clock: inputs already driven at the falling edge; check outputs, then
  // advance the model across the rising edge.
  task automatic cycle(input string tag, output bit stalled);
    bit iss;
    #2;
    check({tag, ":ctrl"}, {27'd0, stall_if, stall_id, flush_if, flush_id, flush_ex},
          {27'd0, m_ctrl()});
    check({tag, ":mask"}, pending_mask, m_mask());
    check({tag, ":err"}, {31'd0, err_spurious_wb}, {31'd0, merr});
    stalled = stall_id;
    iss = id_valid && !ex_redirect && !m_hazard();
    @(posedge clk);
    m_update(iss);
    @(negedge clk);
  endtask

  // Hold the current ID instruction until it issues; bounded by maxc cycles.
  task automatic hold(input string tag, input int maxc, output int n);
    bit s;
    n = 0;
    for (int i = 0; i < maxc; i++) begin
      cycle(tag, s);
      if (!s) break;
      n++;
    end
  endtask

  initial begin
    bit s;
    int n;

    // Reset state
    rst_n = 1'b0; ex_redirect = 1'b0; wb_valid = 1'b0; wb_rd_addr = '0;
    drive_id(1'b1, 0, 0, 2'b00, 0, 1'b0, 0);
    model_reset();
    #3;
    check("reset_outputs", {stall_if, stall_id, flush_if, flush_id, flush_ex, err_spurious_wb,
                            pending_mask[25:0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cycle("post_reset", s);

    // Load-use: one stall cycle
    drive_id(1'b1, 0, 0, 2'b00, 5, 1'b1, 1);
    cycle("lu_issue", s);
    drive_id(1'b1, 5, 0, 2'b01, 6, 1'b1, 0);
    hold("lu_dep", 4, n);
    check("lu_stall_cycles", n, 1);
    idle();
    cycle("lu_idle", s);
    check("lu_mask5", {31'd0, pending_mask[5]}, 32'd0);

    // Multi-cycle: three stall cycles
    drive_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 3);
    cycle("mc_issue", s);
    drive_id(1'b1, 0, 7, 2'b10, 8, 1'b1, 0);
    hold("mc_dep", 8, n);
    check("mc_stall_cycles", n, 3);
    // Forwardable producer: no entry, no stall
    drive_id(1'b1, 0, 0, 2'b00, 9, 1'b1, 0);
    cycle("fwd_issue", s);
    drive_id(1'b1, 9, 0, 2'b01, 10, 1'b0, 0);
    hold("fwd_dep", 4, n);
    check("fwd_stall_cycles", n, 0);
    check("fwd_mask9", {31'd0, pending_mask[9]}, 32'd0);

    // Variable latency: stall until writeback
    drive_id(1'b1, 0, 0, 2'b00, 12, 1'b1, LINF);
    cycle("var_issue", s);
    drive_id(1'b1, 12, 0, 2'b01, 13, 1'b1, 0);
    n = 0;
    for (int i = 0; i < 9; i++) begin
      cycle("var_wait", s);
      n += int'(s);
    end
    check("var_stall_cycles", n, 9);
    wb_valid = 1'b1; wb_rd_addr = 5'd12;
    cycle("var_wb", s);
    check("var_wb_cycle_stall", {31'd0, s}, 32'd1);
    wb_valid = 1'b0;
    cycle("var_go", s);
    check("var_go_stall", {31'd0, s}, 32'd0);
    check("var_mask12", {31'd0, pending_mask[12]}, 32'd0);

    // WAW against a pending variable-latency write
    drive_id(1'b1, 0, 0, 2'b00, 12, 1'b1, LINF);
    cycle("waw_first", s);
    drive_id(1'b1, 0, 0, 2'b00, 12, 1'b1, LINF);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("waw_wait", s);
      n += int'(s);
    end
    check("waw_stall_cycles", n, 4);
    wb_valid = 1'b1; wb_rd_addr = 5'd12;
    cycle("waw_wb", s);
    wb_valid = 1'b0;
    cycle("waw_issue", s);
    check("waw_issue_stall", {31'd0, s}, 32'd0);
    check("waw_reloaded", {31'd0, pending_mask[12]}, 32'd1);
    idle();
    wb_valid = 1'b1; wb_rd_addr = 5'd12;
    cycle("waw_drain", s);
    wb_valid = 1'b0;

    // Redirect dominates a RAW stall; stalled instruction leaves no entry
    drive_id(1'b1, 0, 0, 2'b00, 20, 1'b1, 3);
    cycle("rd_producer", s);
    drive_id(1'b1, 20, 0, 2'b01, 21, 1'b1, LINF);
    ex_redirect = 1'b1;
    cycle("rd_redirect", s);
    check("rd_no_stall", {31'd0, s}, 32'd0);
    ex_redirect = 1'b0;
    idle();
    check("rd_no_entry", {31'd0, pending_mask[21]}, 32'd0);
    for (int i = 0; i < 3; i++) cycle("rd_drain", s);

    // x0 destination and unused / x0 operands
    drive_id(1'b1, 0, 0, 2'b00, 0, 1'b1, LINF);
    cycle("x0_issue", s);
    check("x0_mask", pending_mask, 32'd0);
    drive_id(1'b1, 0, 0, 2'b00, 14, 1'b1, LINF);
    cycle("unused_producer", s);
    drive_id(1'b1, 0, 14, 2'b01, 15, 1'b0, 0);
    hold("unused_dep", 4, n);
    check("unused_stall_cycles", n, 0);
    idle();
    wb_valid = 1'b1; wb_rd_addr = 5'd14;
    cycle("unused_drain", s);

    // Spurious writeback is sticky
    wb_rd_addr = 5'd3;
    cycle("spur_wb", s);
    wb_valid = 1'b0;
    check("spur_err", {31'd0, err_spurious_wb}, 32'd1);
    for (int i = 0; i < 3; i++) cycle("spur_sticky", s);
    check("spur_err_sticky", {31'd0, err_spurious_wb}, 32'd1);

    // Asynchronous reset mid-countdown
    drive_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 5);
    cycle("ar_issue", s);
    drive_id(1'b1, 7, 0, 2'b01, 8, 1'b1, 0);
    cycle("ar_stall", s);
    #2 rst_n = 1'b0;
    #1;
    check("ar_outputs", {26'd0, stall_if, stall_id, flush_if, flush_id, flush_ex,
                         err_spurious_wb}, 32'd0);
    check("ar_mask", pending_mask, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cycle("ar_release", s);
    check("ar_mask_after", pending_mask, 32'd0);

    // Random phase
    for (int k = 0; k < 600; k++) begin
      drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 1) != 0,
               $urandom_range(0, 7));
      ex_redirect = ($urandom_range(0, 7) == 0);
      wb_valid    = ($urandom_range(0, 4) == 0);
      wb_rd_addr  = AW'($urandom_range(1, 7));
      cycle("rnd", s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use hazard unit. It sits between ID and EX and tracks every in-flight register write with a per-register pending bit and a latency countdown.
- It stalls ID on RAW against fixed-latency producers (loads, multi-cycle ALU ops) and against variable-latency producers (divider, cache-miss loads) that retire through a writeback handshake.
- It resolves EX redirects with priority over stalls.
- It drives the IF/ID/EX stall and flush controls of the pipeline.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- REG_ADDR_W, 5, register address width; must equal $clog2(NUM_REGS).
- NUM_SRC, 2, number of ID source operands checked.
- LAT_W, 3, latency field width.
- LAT_INF, 2**LAT_W-1 = 7, id_latency code meaning "variable latency, cleared only by writeback"; fixed latencies are 0..LAT_INF-1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs_addr  in  NUM_SRC*REG_ADDR_W  source addresses; slot i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- id_rs_used  in  NUM_SRC  per-source "operand actually read" qualifier
- id_rd_addr  in  REG_ADDR_W  destination address
- id_reg_write  in  1  instruction writes rd
- id_latency  in  LAT_W  producer latency class
- ex_redirect  in  1  taken branch or jump resolved in EX
- wb_valid  in  1  variable-latency result written this cycle
- wb_rd_addr  in  REG_ADDR_W  destination of that result
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_if  out  1  kill fetched instruction
- flush_id  out  1  kill IF/ID contents
- flush_ex  out  1  insert bubble into ID/EX register
- pending_mask  out  NUM_REGS  registered pending bits; bit 0 is constant 0
- err_spurious_wb  out  1  sticky: wb_valid hit an entry that is not a pending LAT_INF entry

Behaviour:
- Reset (asynchronous, rst_n low):
  - All pending bits, counters and err_spurious_wb clear immediately.
  - While rst_n is low, every output is forced 0.
- Per-register state: pending (1 bit) and cnt (LAT_W bits).
- Issue: issue = id_valid && !stall_id && !flush_id.
  - Gated-off instructions (stalled or flushed) never touch the scoreboard.
- Set on issue, when id_reg_write, rd != 0 and id_latency != 0: pending[rd] <= 1 and cnt[rd] <= id_latency, visible the next cycle.
  - id_latency == 0 means the result is forwardable; no entry is created, and an existing entry for rd is cleared.
- Countdown each cycle for every pending entry with 0 < cnt < LAT_INF:
  - cnt decrements by 1.
  - On the transition 1 -> 0, pending clears in the same edge.
  - Consequence: latency 1 produces exactly one stall cycle, matching classic load-use.
- LAT_INF entries:
  - cnt holds.
  - Clear on wb_valid with wb_rd_addr == rd.
  - Writeback to an entry that is not pending with LAT_INF: state unchanged, err_spurious_wb set until reset.
- Same-edge issue and writeback to the same rd: issue wins (the entry reloads).
- RAW hazard: any slot i with id_valid, id_rs_used[i], rs_i != 0 and pending[rs_i].
- WAW hazard: id_valid, id_reg_write, rd != 0 and pending[rd] with cnt == LAT_INF. This prevents a stale writeback from clearing a younger entry.
- Output priority is combinational, zero latency, all defaults 0:
  - If ex_redirect: flush_if = flush_id = flush_ex = 1; stalls are 0. Redirect dominates; the wrong-path ID instruction is discarded.
  - Else if RAW or WAW: stall_if = stall_id = flush_ex = 1.
- Invariants, asserted under translate_off:
  - Never stall and flush the same stage together.
  - pending_mask[0] == 0.
  - Never cnt == 0 while pending == 1.
- Redirect does not alter existing entries; they belong to older, committed-path instructions.

Decomposition:
- hazard_pkg holds:
  - REG_ADDR_W, LAT_W and LAT_INF.
  - hazard_ctrl_t, a packed struct of the five stall/flush bits.
  - lat_class_e enum: LAT_FWD = 0, LAT_LOAD = 1, LAT_INF.
- Sub-module sb_entry: one register's pending/cnt state, with set, writeback-match and countdown logic plus the spurious-writeback flag.
  - Instantiated NUM_REGS-1 times by a generate loop.
  - The top level holds the hazard compare, the priority logic and the OR-reduction of the error flags.

Test Plan:
- Load-use: issue rd=5, latency 1; next cycle ID reads rs1=5 -> exactly 1 cycle of stall_if/stall_id/flush_ex; issues on the 2nd cycle; pending_mask[5] is 0 after that.
- Multi-cycle: issue rd=7, latency 3; dependent instruction held in ID -> stalled exactly 3 cycles; issue rd=9, latency 0 -> pending_mask[9] stays 0 and the dependent instruction is not stalled.
- Variable latency: issue rd=12, LAT_INF; dependent instruction stalls indefinitely; wb_valid with wb_rd_addr=12 at cycle 10 -> stall drops the same cycle pending[12] clears (next edge); a 2nd LAT_INF write to rd=12 stalls on WAW until that wb.
- Redirect vs stall: RAW stall active and ex_redirect=1 -> flush_if/id/ex=1, stall_if/id=0; stalled instruction creates no entry.
- x0 and unused operands: rd=0 with LAT_INF, or rs=0 / id_rs_used=0 matching a pending reg -> no stall, pending_mask unchanged.
- Spurious writeback and reset: wb_valid to rd=3 when not pending -> err_spurious_wb=1 and sticky; assert rst_n=0 mid-countdown on rd=7 -> all outputs 0 asynchronously, pending_mask 0 after release.
